// File: rtl/mips_defines.sv
// Shared encodings for the multiply/divide unit: request opcodes and FSM states.
// Optional multiply support is enabled by defining MULDIV_MULT_EN.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_OP_DIV   = 3'd0,
      MD_OP_DIVU  = 3'd1,
      MD_OP_MULT  = 3'd2,
      MD_OP_MULTU = 3'd3,
      MD_OP_MTHI  = 3'd4,
      MD_OP_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per run cycle,
// WIDTH iterations after load; last flags the final iteration.
module muldiv_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             run,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH:0]   shifted, diff;

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   assign shifted = {rem_q, quo_q[WIDTH-1]};
   assign diff    = shifted - {1'b0, dvsr_q};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         count_q <= '0;
      end else if (load) begin
         rem_q   <= '0;
         quo_q   <= dividend;
         dvsr_q  <= divisor;
         count_q <= '0;
      end else if (run) begin
         if (!diff[WIDTH]) begin
            rem_q <= diff[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
         count_q <= count_q + 1'b1;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;
   assign last      = (count_q == LAST_COUNT);

endmodule

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: iterative DIV/DIVU, MTHI/MTLO, and
// single-cycle MULT/MULTU when MULDIV_MULT_EN is defined.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             md_valid,
   output logic             md_ready,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] md_op_x,
   input  logic [WIDTH-1:0] md_op_y,
   output logic [WIDTH-1:0] md_hi,
   output logic [WIDTH-1:0] md_lo,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_div_zero
);

   md_state_e state_q, state_d;

   logic             accept, is_div, is_sdiv, load, run, last, mult_go;
   logic [WIDTH-1:0] mag_x, mag_y, quotient, remainder, q_fix, r_fix, x_q;
   logic [2*WIDTH-1:0] product;
   logic             q_neg_q, r_neg_q, zero_q;

   assign accept  = md_valid && (state_q == ST_IDLE);
   assign is_div  = (md_op == MD_OP_DIV) || (md_op == MD_OP_DIVU);
   assign is_sdiv = (md_op == MD_OP_DIV);
   assign mag_x   = (is_sdiv && md_op_x[WIDTH-1]) ? -md_op_x : md_op_x;
   assign mag_y   = (is_sdiv && md_op_y[WIDTH-1]) ? -md_op_y : md_op_y;

`ifdef MULDIV_MULT_EN
   logic               is_mult, mult_signed;
   logic [2*WIDTH-1:0] ext_x, ext_y;

   assign is_mult     = (md_op == MD_OP_MULT) || (md_op == MD_OP_MULTU);
   assign mult_signed = (md_op == MD_OP_MULT);
   // Sign/zero-extend to full width so the truncated 2W product is exact for both forms.
   assign ext_x       = {{WIDTH{mult_signed & md_op_x[WIDTH-1]}}, md_op_x};
   assign ext_y       = {{WIDTH{mult_signed & md_op_y[WIDTH-1]}}, md_op_y};
   assign product     = ext_x * ext_y;
   assign mult_go     = accept && is_mult;
`else
   assign product     = '0;
   assign mult_go     = 1'b0;
`endif

   muldiv_div_core #(.WIDTH(WIDTH)) u_div_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .run       (run),
      .dividend  (mag_x),
      .divisor   (mag_y),
      .quotient  (quotient),
      .remainder (remainder),
      .last      (last)
   );

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      run     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept && is_div) begin
               load    = 1'b1;
               state_d = ST_DIV;
            end else if (mult_go) begin
               state_d = ST_DONE;
            end
         end
         ST_DIV: begin
            run = 1'b1;
            if (last) state_d = ST_FIX;
         end
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         zero_q  <= 1'b0;
      end else if (load) begin
         x_q     <= md_op_x;
         q_neg_q <= is_sdiv && (md_op_x[WIDTH-1] ^ md_op_y[WIDTH-1]);
         r_neg_q <= is_sdiv && md_op_x[WIDTH-1];
         zero_q  <= (md_op_y == '0);
      end else if (mult_go) begin
         zero_q  <= 1'b0;
      end
   end

   // Truncation toward zero: quotient sign from x^y, remainder follows the dividend.
   assign q_fix = q_neg_q ? -quotient  : quotient;
   assign r_fix = r_neg_q ? -remainder : remainder;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         md_hi <= '0;
         md_lo <= '0;
      end else if (state_q == ST_FIX) begin
         md_lo <= zero_q ? '1  : q_fix;
         md_hi <= zero_q ? x_q : r_fix;
      end else if (mult_go) begin
         {md_hi, md_lo} <= product;
      end else if (accept && (md_op == MD_OP_MTHI)) begin
         md_hi <= md_op_x;
      end else if (accept && (md_op == MD_OP_MTLO)) begin
         md_lo <= md_op_x;
      end
   end

   assign md_ready    = (state_q == ST_IDLE);
   assign md_busy     = ~md_ready;
   assign md_done     = (state_q == ST_DONE);
   assign md_div_zero = md_done && zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized DIV/DIVU
// against an arithmetic reference model; MULT checks follow MULDIV_MULT_EN.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [2:0]  md_op = 3'd0;
   logic [31:0] md_op_x = '0;
   logic [31:0] md_op_y = '0;
   logic [31:0] md_hi, md_lo;
   logic        md_busy, md_done, md_div_zero;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .md_valid    (md_valid),
      .md_ready    (md_ready),
      .md_op       (md_op),
      .md_op_x     (md_op_x),
      .md_op_y     (md_op_y),
      .md_hi       (md_hi),
      .md_lo       (md_lo),
      .md_busy     (md_busy),
      .md_done     (md_done),
      .md_div_zero (md_div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference: truncating division with the divide-by-zero and overflow rules.
   function automatic void model_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] hi, output logic [31:0] lo, output bit zero);
      longint sx, sy, q, r;
      sx = sgn ? longint'($signed(x)) : longint'({32'b0, x});
      sy = sgn ? longint'($signed(y)) : longint'({32'b0, y});
      if (y == 32'd0) begin
         lo = '1;
         hi = x;
         zero = 1'b1;
      end else begin
         q = sx / sy;
         r = sx % sy;
         lo = q[31:0];
         hi = r[31:0];
         zero = 1'b0;
      end
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      md_op = op;
      md_op_x = x;
      md_op_y = y;
      md_valid = 1'b1;
      @(posedge clk);
      #1 md_valid = 1'b0;
   endtask

   task automatic run_div(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string name);
      logic [31:0] e_hi, e_lo;
      bit e_zero, ready_ok, stable_ok;
      int lat;
      model_div(op == MD_OP_DIV, x, y, e_hi, e_lo, e_zero);
      issue(op, x, y);
      lat = -1;
      ready_ok = 1'b1;
      stable_ok = 1'b1;
      for (int c = 1; c <= 60 && lat < 0; c++) begin
         @(negedge clk);
         if (md_done) lat = c;
         else begin
            if (md_ready || !md_busy) ready_ok = 1'b0;
            if (md_hi !== exp_hi || md_lo !== exp_lo) stable_ok = 1'b0;
         end
      end
      checks++;
      if (lat != 34) begin
         errors++;
         $display("FAIL %s latency: got %0d want 34 (x=%h y=%h)", name, lat, x, y);
      end
      checks++;
      if (!ready_ok || !stable_ok) begin
         errors++;
         $display("FAIL %s busy_phase: ready_low_ok=%0d hilo_stable_ok=%0d want 1 1", name, ready_ok, stable_ok);
      end
      if (lat > 0) begin
         checks++;
         if (md_lo !== e_lo || md_hi !== e_hi || md_div_zero !== e_zero) begin
            errors++;
            $display("FAIL %s result: x=%h y=%h got lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b",
                     name, x, y, md_lo, md_hi, md_div_zero, e_lo, e_hi, e_zero);
         end
      end
      exp_hi = e_hi;
      exp_lo = e_lo;
      @(negedge clk);
      checks++;
      if (md_done !== 1'b0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_done: done=%b ready=%b want 0 1", name, md_done, md_ready);
      end
   endtask

   task automatic expect_quiet(input int cycles, input string name);
      bit saw_done;
      saw_done = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (md_done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done || md_ready !== 1'b1 || md_hi !== exp_hi || md_lo !== exp_lo) begin
         errors++;
         $display("FAIL %s quiet: done_seen=%0d ready=%b hi=%h lo=%h want 0 1 hi=%h lo=%h",
                  name, saw_done, md_ready, md_hi, md_lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (md_hi !== 32'd0 || md_lo !== 32'd0 || md_ready !== 1'b1 || md_busy !== 1'b0 ||
          md_done !== 1'b0 || md_div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: hi=%h lo=%h ready=%b busy=%b done=%b dz=%b want 0 0 1 0 0 0",
                  md_hi, md_lo, md_ready, md_busy, md_done, md_div_zero);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed_div();
      run_div(MD_OP_DIVU, 32'd100, 32'd7, "divu_100_7");
      run_div(MD_OP_DIV, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      run_div(MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
      run_div(MD_OP_DIVU, 32'd5, 32'd0, "divu_by_zero");
      run_div(MD_OP_DIV, 32'hFFFFFF00, 32'd0, "div_by_zero");
      run_div(MD_OP_DIV, 32'd7, 32'hFFFFFFFE, "div_7_m2");
   endtask

   task automatic test_random_div();
      logic [31:0] x, y;
      logic [2:0] op;
      for (int i = 0; i < 20; i++) begin
         op = ($urandom_range(0, 1) == 0) ? MD_OP_DIV : MD_OP_DIVU;
         x = $urandom();
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = $urandom_range(1, 15);
            2: y = 32'hFFFFFFFF;
            3: x = 32'h80000000;
            default: y = $urandom();
         endcase
         if (y === 32'hx) y = $urandom();
         run_div(op, x, y, "rand_div");
      end
   endtask

   task automatic test_mt_back_to_back();
      @(negedge clk);
      md_op = MD_OP_MTHI;
      md_op_x = 32'h1234;
      md_valid = 1'b1;
      @(posedge clk);
      #1;
      md_op = MD_OP_MTLO;
      md_op_x = 32'h5678;
      @(posedge clk);
      #1 md_valid = 1'b0;
      exp_hi = 32'h1234;
      exp_lo = 32'h5678;
      expect_quiet(4, "mthi_mtlo");
   endtask

   task automatic test_unused_ops();
      issue(3'd6, 32'hDEADBEEF, 32'h1);
      expect_quiet(3, "op6_noop");
      issue(3'd7, 32'hCAFEF00D, 32'h2);
      expect_quiet(3, "op7_noop");
   endtask

   task automatic test_mult(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input string name);
`ifdef MULDIV_MULT_EN
      logic [63:0] prod;
      if (op == MD_OP_MULT) prod = 64'(longint'($signed(x)) * longint'($signed(y)));
      else prod = {32'b0, x} * {32'b0, y};
      issue(op, x, y);
      @(negedge clk);
      checks++;
      if (md_done !== 1'b1 || md_div_zero !== 1'b0 || md_hi !== prod[63:32] || md_lo !== prod[31:0]) begin
         errors++;
         $display("FAIL %s: done=%b dz=%b hi=%h lo=%h want 1 0 hi=%h lo=%h",
                  name, md_done, md_div_zero, md_hi, md_lo, prod[63:32], prod[31:0]);
      end
      exp_hi = prod[63:32];
      exp_lo = prod[31:0];
      expect_quiet(2, name);
`else
      issue(op, x, y);
      expect_quiet(3, name);
`endif
   endtask

   task automatic test_abort_reset();
      bit saw_done;
      issue(MD_OP_MTHI, 32'hA5A5A5A5, 32'd0);
      exp_hi = 32'hA5A5A5A5;
      issue(MD_OP_DIV, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (md_hi !== 32'd0 || md_lo !== 32'd0 || md_ready !== 1'b1 || md_busy !== 1'b0 || md_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: hi=%h lo=%h ready=%b busy=%b done=%b want 0 0 1 0 0",
                  md_hi, md_lo, md_ready, md_busy, md_done);
      end
      exp_hi = '0;
      exp_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (md_done) saw_done = 1'b1;
      end
      checks++;
      if (saw_done || md_hi !== 32'd0 || md_lo !== 32'd0) begin
         errors++;
         $display("FAIL abort_release: done_seen=%0d hi=%h lo=%h want 0 0 0", saw_done, md_hi, md_lo);
      end
   endtask

   initial begin
      test_reset();
      test_directed_div();
      test_mt_back_to_back();
      test_unused_ops();
      test_mult(MD_OP_MULT, 32'hFFFFFFFD, 32'd4, "mult_m3_4");
      test_mult(MD_OP_MULTU, 32'hFFFFFFFF, 32'd2, "multu_max_2");
      run_div(MD_OP_DIVU, 32'd9, 32'd0, "div_zero_after_mult");
      test_random_div();
      test_abort_reset();
      run_div(MD_OP_DIVU, 32'd100, 32'd7, "divu_after_reset");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/HI/LO width (only 32 supported).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: md_valid  input  1  request present.
REQ-005 SHALL have port: md_ready  output  1  unit can accept request.
REQ-006 SHALL have port: md_op  input  3  DIV, DIVU, MULT, MULTU, MTHI, MTLO.
REQ-007 SHALL have port: md_op_x  input  32  dividend / multiplicand / MTHI-MTLO data.
REQ-008 SHALL have port: md_op_y  input  32  divisor / multiplier.
REQ-009 SHALL have port: md_hi  output  32  HI register (remainder / product upper).
REQ-010 SHALL have port: md_lo  output  32  LO register (quotient / product lower).
REQ-011 SHALL have port: md_busy  output  1  operation in flight (= ~md_ready).
REQ-012 SHALL have port: md_done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: md_div_zero  output  1  divisor was zero; valid only with md_done.

Function
REQ-014 SHALL accept a request on a rising edge where md_valid & md_ready; operands and op latched then.
REQ-015 SHALL drive md_ready high only in IDLE; md_valid while busy is ignored, upstream holds it.
REQ-016 SHALL use FSM states IDLE, DIV, FIX, DONE: IDLE->DIV on accepted DIV/DIVU; DIV 32 cycles then FIX; FIX->DONE; DONE->IDLE.
REQ-017 SHALL divide by restoring algorithm on magnitudes, one quotient bit per cycle, 32 iterations.
REQ-018 SHALL in FIX apply signs for DIV: quotient negated if x[31]^y[31], remainder takes sign of x (truncation toward zero); write LO=quotient, HI=remainder.
REQ-019 SHALL assert md_done for exactly the DONE cycle, 34 cycles after the accepting edge, with new md_hi/md_lo visible in that same cycle.
REQ-020 SHALL on divisor zero (DIV or DIVU) keep 34-cycle latency, produce LO=32'hFFFFFFFF, HI=md_op_x, and assert md_div_zero with md_done.
REQ-021 SHALL on DIV 0x80000000 / 0xFFFFFFFF produce LO=0x80000000, HI=0, md_div_zero=0.
REQ-022 SHALL write MTHI/MTLO data to HI/LO on the accepting edge, stay in IDLE, and produce no md_done.
REQ-023 SHALL keep md_hi/md_lo stable except on a completing write or MTHI/MTLO.
REQ-024 SHALL treat unused md_op encodings as no-ops: accepted, no state change, no md_done.

Reset
REQ-025 SHALL on rst_n low immediately force IDLE, md_hi=md_lo=0, md_done=0, md_div_zero=0, md_ready=1, md_busy=0.
REQ-026 SHALL abort any in-flight operation on reset without writing HI/LO and produce no md_done after release.

Configuration
REQ-027 SHALL compile MULT/MULTU support only when macro MULDIV_MULT_EN is defined.
REQ-028 SHALL with MULDIV_MULT_EN: IDLE->DONE on accepted MULT/MULTU, write 64-bit signed/unsigned product {HI,LO} at that edge, md_done 1 cycle after accept (latency 1 edge + 1 cycle).
REQ-029 SHALL without MULDIV_MULT_EN: treat MULT/MULTU as no-ops per REQ-024.

Structure
REQ-030 SHALL place md_op encodings (MD_OP_DIV, MD_OP_DIVU, MD_OP_MULT, MD_OP_MULTU, MD_OP_MTHI, MD_OP_MTLO) and FSM state encodings in mips_defines.v.
REQ-031 SHALL isolate the iterative magnitude divider (partial remainder, quotient shift register, iteration counter) in sub-module muldiv_div_core; sign handling, FSM and HI/LO stay in muldiv_unit.

Verification
REQ-032 SHALL test DIVU 100/7 -> LO=14, HI=2, md_done exactly 34 cycles after accept, md_ready low throughout.
REQ-033 SHALL test DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 SHALL test DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, md_div_zero=1 with md_done.
REQ-035 SHALL test rst_n low at cycle 10 of a DIV -> HI=LO=0, md_ready=1 immediately, no md_done after release.
REQ-036 SHALL test MTHI 0x1234 then MTLO 0x5678 back-to-back -> HI=0x1234, LO=0x5678, no md_done; MULT 0xFFFFFFFD*4 with MULDIV_MULT_EN -> HI=0xFFFFFFFF, LO=0xFFFFFFF4; without it, HI/LO unchanged.
